mnist_result_counter: RTL and testbench

MNIST_RESULT_COUNTER -- requirements
Module: mnist_result_counter

---
 rtl/mnist_result_counter_pkg.sv | 14 +
 rtl/mnist_onehot_compare.sv | 26 ++
 rtl/mnist_result_counter.sv | 148 ++++++++++++++
 tb/tb_mnist_result_counter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_result_counter_pkg.sv
// Shared widths and state encodings for the MNIST result-counting blocks.
package mnist_result_counter_pkg;

    localparam int unsigned MNIST_USER_WIDTH  = 8;
    localparam int unsigned MNIST_NUM_CLASS   = 10;
    localparam int unsigned MNIST_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mnist_onehot_compare.sv
// Combinational classification of one network result against its expected label.
module mnist_onehot_compare #(
    parameter int unsigned USER_WIDTH = mnist_result_counter_pkg::MNIST_USER_WIDTH,
    parameter int unsigned NUM_CLASS  = mnist_result_counter_pkg::MNIST_NUM_CLASS
) (
    input  logic [USER_WIDTH-1:0] in_user,
    input  logic [NUM_CLASS-1:0]  in_data,
    output logic                  match_c,
    output logic                  hit_c,
    output logic                  label_error_c
);

    logic [NUM_CLASS-1:0] onehot_c;

    // An out-of-range label yields an all-zero reference so it can never hit or match.
    always_comb begin
        onehot_c = '0;
        for (int unsigned i = 0; i < NUM_CLASS; i++) begin
            onehot_c[i] = (32'(in_user) == i);
        end
        label_error_c = (32'(in_user) >= NUM_CLASS);
        match_c       = !label_error_c && (in_data == onehot_c);
        hit_c         = |(in_data & onehot_c);
    end

endmodule

// File: rtl/mnist_result_counter.sv
// Counts classification results over a run of frame_num samples, with a
// per-class match histogram readable through rd_class/rd_count.
module mnist_result_counter #(
    parameter int unsigned USER_WIDTH  = mnist_result_counter_pkg::MNIST_USER_WIDTH,
    parameter int unsigned NUM_CLASS   = mnist_result_counter_pkg::MNIST_NUM_CLASS,
    parameter int unsigned COUNT_WIDTH = mnist_result_counter_pkg::MNIST_COUNT_WIDTH
) (
    input  logic                   reset,
    input  logic                   clk,
    input  logic                   cke,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] frame_num,
    input  logic [USER_WIDTH-1:0]  in_user,
    input  logic [NUM_CLASS-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] total_count,
    output logic [COUNT_WIDTH-1:0] match_count,
    output logic [COUNT_WIDTH-1:0] hit_count,
    output logic                   label_error,
    input  logic [USER_WIDTH-1:0]  rd_class,
    output logic [COUNT_WIDTH-1:0] rd_count
);

    import mnist_result_counter_pkg::*;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                 state, state_next;
    logic                   s1_valid;
    logic [USER_WIDTH-1:0]  s1_user;
    logic [NUM_CLASS-1:0]   s1_data;
    logic [COUNT_WIDTH-1:0] frame_q;
    logic [COUNT_WIDTH-1:0] class_count [NUM_CLASS];

    logic                   match_c, hit_c, label_bad_c;
    logic                   accept_c, count_en_c;
    logic [COUNT_WIDTH-1:0] total_inc_c;
    logic [COUNT_WIDTH-1:0] rd_next_c;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + COUNT_WIDTH'(1);
    endfunction

    mnist_onehot_compare #(
        .USER_WIDTH (USER_WIDTH),
        .NUM_CLASS  (NUM_CLASS)
    ) u_compare (
        .in_user       (s1_user),
        .in_data       (s1_data),
        .match_c       (match_c),
        .hit_c         (hit_c),
        .label_error_c (label_bad_c)
    );

    // Next state; stage 2 only counts in RUN while the run is still short of frame_q.
    always_comb begin
        state_next  = state;
        total_inc_c = sat_inc(total_count);
        accept_c    = (state == ST_RUN) && in_valid && !start;
        count_en_c  = s1_valid && (state == ST_RUN) && (total_count != frame_q);
        case (state)
            ST_RUN: begin
                if ((total_count == frame_q) || (count_en_c && (total_inc_c == frame_q))) begin
                    state_next = ST_DONE;
                end
            end
            default: ;
        endcase
        if (start) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        rd_next_c = '0;
        for (int unsigned i = 0; i < NUM_CLASS; i++) begin
            if (32'(rd_class) == i) begin
                rd_next_c = class_count[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (cke) begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
            done  <= (state_next == ST_DONE);
        end
    end

    // Stage 1 captures the sample, stage 2 updates the counters; start wins over both.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_user     <= '0;
            s1_data     <= '0;
            frame_q     <= '0;
            total_count <= '0;
            match_count <= '0;
            hit_count   <= '0;
            label_error <= 1'b0;
            rd_count    <= '0;
            for (int unsigned i = 0; i < NUM_CLASS; i++) begin
                class_count[i] <= '0;
            end
        end else if (cke) begin
            rd_count <= rd_next_c;
            s1_valid <= accept_c;
            if (accept_c) begin
                s1_user <= in_user;
                s1_data <= in_data;
            end
            if (start) begin
                frame_q     <= frame_num;
                total_count <= '0;
                match_count <= '0;
                hit_count   <= '0;
                label_error <= 1'b0;
                for (int unsigned i = 0; i < NUM_CLASS; i++) begin
                    class_count[i] <= '0;
                end
            end else if (count_en_c) begin
                total_count <= total_inc_c;
                if (match_c) begin
                    match_count <= sat_inc(match_count);
                end
                if (hit_c) begin
                    hit_count <= sat_inc(hit_count);
                end
                if (label_bad_c) begin
                    label_error <= 1'b1;
                end
                for (int unsigned i = 0; i < NUM_CLASS; i++) begin
                    if (match_c && (32'(s1_user) == i)) begin
                        class_count[i] <= sat_inc(class_count[i]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mnist_result_counter.sv
// Scoreboard bench: run results and readouts are queued by the stimulus and
// checked by a monitor when done rises or a readout becomes due.
module tb_mnist_result_counter;

    localparam int unsigned UW = 8;
    localparam int unsigned NC = 10;
    localparam int unsigned CW = 16;
    localparam int unsigned CW4 = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cke = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] frame_num = '0;
    logic [UW-1:0] in_user = '0;
    logic [NC-1:0] in_data = '0;
    logic [UW-1:0] rd_class = '0;

    logic          busy, done, label_error;
    logic [CW-1:0] total_count, match_count, hit_count, rd_count;
    logic           busy4, done4, label_error4;
    logic [CW4-1:0] total4, match4, hit4, rd4;

    mnist_result_counter dut (
        .reset(reset), .clk(clk), .cke(cke), .start(start), .frame_num(frame_num),
        .in_user(in_user), .in_data(in_data), .in_valid(in_valid),
        .busy(busy), .done(done), .total_count(total_count), .match_count(match_count),
        .hit_count(hit_count), .label_error(label_error), .rd_class(rd_class), .rd_count(rd_count)
    );

    mnist_result_counter #(.COUNT_WIDTH(CW4)) dut4 (
        .reset(reset), .clk(clk), .cke(cke), .start(start), .frame_num(frame_num[CW4-1:0]),
        .in_user(in_user), .in_data(in_data), .in_valid(in_valid),
        .busy(busy4), .done(done4), .total_count(total4), .match_count(match4),
        .hit_count(hit4), .label_error(label_error4), .rd_class(rd_class), .rd_count(rd4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] total;
        logic [CW-1:0] match;
        logic [CW-1:0] hit;
        logic          lerr;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          exp4_q[$];
    logic [CW-1:0] rd_q[$];
    exp_t          e, e4;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_events = 0;
    int   n_runs = 0;
    int   last_cyc = 0;
    logic done_prev = 1'b0;
    logic done4_prev = 1'b0;
    logic rd_req = 1'b0;
    logic rd_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= rd_req;
    end

    // Monitor: compare a queued run result on each rising done, and queued readouts.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            done_events <= done_events + 1;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("total_count", 32'(total_count), 32'(e.total));
                chk("match_count", 32'(match_count), 32'(e.match));
                chk("hit_count", 32'(hit_count), 32'(e.hit));
                chk("label_error", 32'(label_error), 32'(e.lerr));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(busy), 32'(0));
            end
        end
        done_prev <= done;
        if (done4 && !done4_prev && exp4_q.size() != 0) begin
            e4 = exp4_q.pop_front();
            chk("total4", 32'(total4), 32'(e4.total));
            chk("match4", 32'(match4), 32'(e4.match));
            chk("hit4", 32'(hit4), 32'(e4.hit));
            chk("done4_cycle", 32'(cyc), 32'(e4.cyc));
        end
        done4_prev <= done4;
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 32'(rd_pend), 32'(0));
            end else begin
                chk("rd_count", 32'(rd_count), 32'(rd_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int fn);
        start     = 1'b1;
        frame_num = CW'(fn);
        last_cyc  = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic send(input int u, input logic [NC-1:0] d);
        in_valid = 1'b1;
        in_user  = UW'(u);
        in_data  = d;
        last_cyc = cyc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic push(input int t, input int m, input int h, input logic l, input int c);
        exp_t x;
        x.total = CW'(t);
        x.match = CW'(m);
        x.hit   = CW'(h);
        x.lerr  = l;
        x.cyc   = c;
        exp_q.push_back(x);
        n_runs++;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && done_events < n_runs; i++) begin
            step();
        end
        chk("done_seen", 32'(done_events), 32'(n_runs));
    endtask

    task automatic rd_check(input int cls, input int exp);
        rd_class = UW'(cls);
        rd_req   = 1'b1;
        rd_q.push_back(CW'(exp));
        step();
        rd_req = 1'b0;
        step();
    endtask

    initial begin
        exp_t x4;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_total", 32'(total_count), 32'(0));
        chk("rst_match", 32'(match_count), 32'(0));
        chk("rst_hit", 32'(hit_count), 32'(0));
        chk("rst_label_error", 32'(label_error), 32'(0));
        chk("rst_rd_count", 32'(rd_count), 32'(0));
        reset = 1'b0;
        step();

        // Four exact one-hot samples, labels 0..3.
        do_start(4);
        for (int u = 0; u < 4; u++) send(u, NC'(1) << u);
        push(4, 4, 4, 1'b0, last_cyc + 2);
        wait_done();
        rd_check(2, 1);
        rd_check(0, 1);
        rd_check(11, 0);
        send(1, NC'(2));
        step();
        step();
        chk("ignored_in_done", 32'(total_count), 32'(4));
        chk("done_held", 32'(done), 32'(1));

        // Multi-hot containing the label bit: hit but not match.
        do_start(1);
        send(5, 10'b0000100001);
        push(1, 0, 1, 1'b0, last_cyc + 2);
        wait_done();

        // All-zero result: neither hit nor match.
        do_start(1);
        send(3, '0);
        push(1, 0, 0, 1'b0, last_cyc + 2);
        wait_done();

        // Out-of-range label.
        do_start(1);
        send(12, NC'(1));
        push(1, 0, 0, 1'b1, last_cyc + 2);
        wait_done();
        repeat (3) step();
        chk("label_error_sticky", 32'(label_error), 32'(1));

        // Start coincident with a sample mid-run.
        do_start(3);
        send(1, NC'(2));
        in_valid  = 1'b1;
        in_user   = UW'(2);
        in_data   = NC'(4);
        start     = 1'b1;
        frame_num = CW'(2);
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_clear_total", 32'(total_count), 32'(0));
        chk("start_clear_label_error", 32'(label_error), 32'(0));
        chk("start_busy", 32'(busy), 32'(1));
        step();
        chk("start_sample_dropped", 32'(total_count), 32'(0));
        send(3, NC'(8));
        send(4, NC'(16));
        push(2, 2, 2, 1'b0, last_cyc + 2);
        wait_done();
        rd_check(2, 0);
        rd_check(4, 1);
        rd_check(1, 0);

        // Empty run.
        do_start(0);
        push(0, 0, 0, 1'b0, last_cyc + 2);
        wait_done();

        // Clock-enable stall with a sample in stage 1.
        do_start(1);
        send(7, NC'(128));
        push(1, 1, 1, 1'b0, last_cyc + 5);
        cke = 1'b0;
        repeat (3) step();
        chk("cke_hold_total", 32'(total_count), 32'(0));
        chk("cke_hold_busy", 32'(busy), 32'(1));
        cke = 1'b1;
        wait_done();
        step();
        step();
        chk("cke_single_update", 32'(total_count), 32'(1));

        // Reset in the middle of a run.
        do_start(5);
        send(0, NC'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrun_rst_busy", 32'(busy), 32'(0));
        chk("midrun_rst_total", 32'(total_count), 32'(0));
        step();
        chk("midrun_rst_pipe_flushed", 32'(total_count), 32'(0));

        // 20 matching samples against frame_num 15; the 4-bit instance tops out exactly.
        do_start(15);
        for (int i = 0; i < 20; i++) begin
            send(i % 10, NC'(1) << (i % 10));
            if (i == 14) begin
                push(15, 15, 15, 1'b0, last_cyc + 2);
                x4.total = CW'(15);
                x4.match = CW'(15);
                x4.hit   = CW'(15);
                x4.lerr  = 1'b0;
                x4.cyc   = last_cyc + 2;
                exp4_q.push_back(x4);
            end
        end
        wait_done();
        chk("extra_ignored_total", 32'(total_count), 32'(15));
        chk("w4_total", 32'(total4), 32'(15));
        chk("w4_match", 32'(match4), 32'(15));
        chk("w4_done", 32'(done4), 32'(1));
        rd_class = UW'(0);
        rd_req   = 1'b1;
        rd_q.push_back(CW'(2));
        step();
        rd_req = 1'b0;
        chk("w4_rd_class0", 32'(rd4), 32'(2));
        step();
        rd_class = UW'(9);
        step();
        chk("w4_rd_class9", 32'(rd4), 32'(1));

        repeat (3) step();
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
        chk("exp4_q_drained", 32'(exp4_q.size()), 32'(0));
        chk("rd_q_drained", 32'(rd_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
